ks_adder_rr_arbiter: RTL



---
 rtl/ks_adder_rr_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/ks_adder_rr_arbiter.sv
// ks_adder_rr_arbiter: round-robin sharing of one Kogge-Stone adder with a registered response slot.
// Optional macro KS_ARB_SAT_EN makes a carry-out saturate rsp_sum to all-ones.
module ks_adder #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int L = $clog2(W);
    logic [W-1:0] g [0:L];
    logic [W-1:0] p [0:L];
    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        g[0][0] = g[0][0] | (p[0][0] & cin);
        for (int l = 0; l < L; l++) begin
            g[l+1] = g[l];
            p[l+1] = p[l];
            for (int i = 1 << l; i < W; i++) begin
                g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
            end
        end
    end
    assign sum  = p[0] ^ {g[L][W-2:0], cin};
    assign cout = g[L][W-1];
endmodule

module ks_adder_rr_arbiter #(
    parameter int WIDTH = 24,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout
);
    localparam int IDW = $clog2(NREQ);
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant;
    logic             found, can_accept, accept;
    logic [WIDTH-1:0] op_a, op_b, add_sum, res_sum;
    logic             op_cin, add_cout;
    // Descending scan so the requester closest to rr_ptr is the one left standing.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                grant = IDW'((int'(rr_ptr_q) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign accept     = found && can_accept && !rst;
    assign req_ready  = accept ? (NREQ'(1) << grant) : '0;
    assign op_a       = req_a[int'(grant)*WIDTH +: WIDTH];
    assign op_b       = req_b[int'(grant)*WIDTH +: WIDTH];
    assign op_cin     = req_cin[grant];
    ks_adder #(.W(WIDTH)) u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );
`ifdef KS_ARB_SAT_EN
    assign res_sum = add_cout ? '1 : add_sum;
`else
    assign res_sum = add_sum;
`endif
    always_comb begin
        rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);
        rsp_sum_d   = accept ? res_sum : rsp_sum_q;
        rsp_cout_d  = accept ? add_cout : rsp_cout_q;
        rsp_id_d    = accept ? grant : rsp_id_q;
        rr_ptr_d    = accept ? ((int'(grant) == NREQ - 1) ? '0 : grant + 1'b1) : rr_ptr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
endmodule
